// File: rtl/input_feeder.sv
// Input feeder for a systolic array: streams N words from the input memory
// and skews lane r by r+1 register stages so row r sees vector k at cycle 3+k+r.
module input_feeder #(
    parameter int WIDTH  = 8,
    parameter int ROW    = 4,
    parameter int I_SIZE = 512,
    localparam int AW    = $clog2(I_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        i_offset,
    input  logic [AW-1:0]        i_rows,
    output logic                 mem_ren,
    output logic [AW-1:0]        mem_addr,
    input  logic [ROW*WIDTH-1:0] mem_rdata,
    output logic [ROW*WIDTH-1:0] array_in,
    output logic [ROW-1:0]       array_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic            mem_ren_q;
    logic [AW-1:0]   mem_addr_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_vld_q;
    logic [ROW-1:0]  lane_pend;

    // Read data is only meaningful in the cycle after a read; this flag gates capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            rd_vld_q <= mem_ren_q;
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic [WIDTH-1:0] dat_q [r+1];
        logic [WIDTH-1:0] dat_d [r+1];
        logic [r:0]       vld_q;
        logic [r:0]       vld_d;

        always_comb begin
            // NOTE: the first element of every shift stage is assigned on all
            // paths, so no latch is inferred for any stage.
            vld_d[0] = rd_vld_q;
            dat_d[0] = rd_vld_q ? mem_rdata[r*WIDTH +: WIDTH] : '0;
            for (int s = 1; s <= r; s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the skew stages are plain flops, not a RAM, so they are
                // cleared on reset; no stale valid may survive an aborted transfer.
                vld_q <= '0;
                for (int s = 0; s <= r; s++) begin
                    dat_q[s] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int s = 0; s <= r; s++) begin
                    dat_q[s] <= dat_d[s];
                end
            end
        end

        assign array_valid[r]            = vld_q[r];
        assign array_in[r*WIDTH +: WIDTH] = vld_q[r] ? dat_q[r] : '0;
        assign lane_pend[r]              = |vld_d;
    end

    // Leaving DRAIN when the stages will be empty next cycle lands done
    // exactly one cycle after the last lane's last valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (i_rows == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            mem_ren_q  <= 1'b1;
                            mem_addr_q <= i_offset;
                            cnt_q      <= i_rows - 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (cnt_q == '0) begin
                        state_q    <= DRAIN;
                        mem_ren_q  <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        mem_addr_q <= (mem_addr_q == AW'(I_SIZE - 1)) ? '0
                                                                       : mem_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!(|lane_pend)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_ren_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_input_feeder.sv
// Bench for input_feeder: a scoreboard of expected reads, per-lane beats, done
// pulses and busy windows is filled on each accepted start and drained cycle by cycle.
module tb_input_feeder;

    localparam int WIDTH  = 8;
    localparam int ROW    = 4;
    localparam int I_SIZE = 512;
    localparam int AW     = $clog2(I_SIZE);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        i_offset = '0;
    logic [AW-1:0]        i_rows = '0;
    logic                 mem_ren;
    logic [AW-1:0]        mem_addr;
    logic [ROW*WIDTH-1:0] mem_rdata = '0;
    logic [ROW*WIDTH-1:0] array_in;
    logic [ROW-1:0]       array_valid;
    logic                 busy;
    logic                 done;

    input_feeder #(.WIDTH(WIDTH), .ROW(ROW), .I_SIZE(I_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .i_offset(i_offset), .i_rows(i_rows),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .array_in(array_in), .array_valid(array_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
    typedef struct { int cyc; logic [WIDTH-1:0] data; } beat_t;
    typedef struct { int lo; int hi; } win_t;
    typedef struct {
        logic [AW-1:0] off;
        logic [AW-1:0] rows;
        logic [AW-1:0] exp_last_addr;
        int            exp_done_lat;
    } vec_t;

    rd_t   rd_q[$];
    beat_t lane_q[ROW][$];
    int    done_q[$];
    win_t  busy_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int free_from = 0;
    int last_done_cyc = -1;
    logic [AW-1:0] last_rd_addr = '0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] mem_byte(input logic [AW-1:0] a, input int r);
        logic [3:0] rn;
        rn = 4'(r);
        return {a[3:0], rn};
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: one-cycle read latency; garbage on the bus when no read was issued.
    logic          ren_s;
    logic [AW-1:0] addr_s;
    always @(negedge clk) begin
        ren_s  = mem_ren;
        addr_s = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < ROW; r++) begin
            mem_rdata[r*WIDTH +: WIDTH] = ren_s ? mem_byte(addr_s, r) : WIDTH'($urandom);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_ren;
            bit exp_v;
            bit exp_done;
            bit exp_busy;
            exp_ren = rd_q.size() > 0 && rd_q[0].cyc == cyc;
            check("mem_ren", mem_ren, exp_ren);
            if (exp_ren) begin
                check("mem_addr", mem_addr, rd_q[0].addr);
                void'(rd_q.pop_front());
            end
            if (mem_ren) last_rd_addr = mem_addr;
            for (int r = 0; r < ROW; r++) begin
                exp_v = lane_q[r].size() > 0 && lane_q[r][0].cyc == cyc;
                check($sformatf("valid[%0d]", r), array_valid[r], exp_v);
                if (exp_v) begin
                    check($sformatf("lane%0d_data", r), array_in[r*WIDTH +: WIDTH], lane_q[r][0].data);
                    void'(lane_q[r].pop_front());
                end else begin
                    check($sformatf("lane%0d_zero", r), array_in[r*WIDTH +: WIDTH], 0);
                end
            end
            exp_done = done_q.size() > 0 && done_q[0] == cyc;
            check("done", done, exp_done);
            if (exp_done) void'(done_q.pop_front());
            if (done) last_done_cyc = cyc;
            while (busy_q.size() > 0 && busy_q[0].hi < cyc) void'(busy_q.pop_front());
            exp_busy = busy_q.size() > 0 && busy_q[0].lo <= cyc;
            check("busy", busy, exp_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard update for a start driven in cycle c0; ignored while a transfer is live.
    task automatic offer_start(input int c0, input logic [AW-1:0] off, input logic [AW-1:0] n);
        int d;
        logic [AW-1:0] a;
        if (c0 >= free_from) begin
            for (int k = 0; k < int'(n); k++) begin
                a = AW'((int'(off) + k) % I_SIZE);
                rd_q.push_back(rd_t'{c0 + 1 + k, a});
                for (int r = 0; r < ROW; r++) lane_q[r].push_back(beat_t'{c0 + 3 + k + r, mem_byte(a, r)});
            end
            d = (n == 0) ? c0 + 1 : c0 + int'(n) + ROW + 2;
            done_q.push_back(d);
            busy_q.push_back(win_t'{c0 + 1, d});
            free_from = d;
        end
    endtask

    task automatic drive_start(input logic [AW-1:0] off, input logic [AW-1:0] n, output int c0);
        c0 = cyc;
        i_offset = off;
        i_rows = n;
        start = 1'b1;
        offer_start(c0, off, n);
        tick();
        start = 1'b0;
        i_offset = AW'($urandom);
        i_rows = AW'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int c0;
        drive_start(v.off, v.rows, c0);
        while (cyc < c0 + v.exp_done_lat + 2) tick();
        check("done_latency", 64'(last_done_cyc - c0), 64'(v.exp_done_lat));
        if (v.rows != 0) check("last_addr", last_rd_addr, v.exp_last_addr);
    endtask

    vec_t vecs[5];

    initial begin
        int c0;
        int c1;
        vecs[0] = '{off: 9'h010, rows: 9'd4,  exp_last_addr: 9'h013, exp_done_lat: 10};
        vecs[1] = '{off: 9'h1FE, rows: 9'd4,  exp_last_addr: 9'h001, exp_done_lat: 10};
        vecs[2] = '{off: 9'h055, rows: 9'd0,  exp_last_addr: 9'h000, exp_done_lat: 1};
        vecs[3] = '{off: 9'h0FF, rows: 9'd1,  exp_last_addr: 9'h0FF, exp_done_lat: 7};
        vecs[4] = '{off: 9'h1F0, rows: 9'd20, exp_last_addr: 9'h003, exp_done_lat: 26};

        repeat (3) tick();
        check("reset_outputs", {mem_ren, mem_addr, array_in, array_valid, busy, done}, 0);
        rst_n = 1'b1;
        free_from = cyc;
        chk_en = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start pulsed mid-transfer is ignored; start in the done cycle chains a new transfer.
        drive_start(9'h040, 9'd6, c0);
        while (cyc < c0 + 5) tick();
        drive_start(9'h100, 9'd3, c1);
        while (cyc < c0 + 6 + ROW + 2) tick();
        drive_start(9'h080, 9'd2, c1);
        check("b2b_first_done", 64'(last_done_cyc - c0), 64'(12));
        while (cyc < c1 + 2 + ROW + 4) tick();
        check("b2b_second_done", 64'(last_done_cyc - c1), 64'(8));
        check("b2b_last_addr", last_rd_addr, 9'h081);

        // Reset in cycle 4 of an 8-word transfer abandons it entirely.
        drive_start(9'h020, 9'd8, c0);
        while (cyc < c0 + 4) tick();
        rst_n = 1'b0;
        rd_q.delete();
        done_q.delete();
        busy_q.delete();
        for (int r = 0; r < ROW; r++) lane_q[r].delete();
        #1;
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_array_in", array_in, 0);
        check("rst_array_valid", array_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        free_from = cyc;
        c1 = last_done_cyc;
        repeat (15) tick();
        check("no_done_after_abort", 64'(last_done_cyc), 64'(c1));
        run_vec(vecs[0]);

        repeat (2) tick();
        n_checks++;
        if (rd_q.size() + done_q.size() + lane_q[0].size() + lane_q[ROW-1].size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     rd_q.size() + done_q.size() + lane_q[0].size() + lane_q[ROW-1].size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
